shift_seq_unit: RTL and testbench

Parametrised, handshaked shift engine for the bit_shift library. It accepts a WIDTH-bit operand, a shift amount and a mode, and shifts one position per clock. It then holds the result and the last bit shifted out until the consumer takes it. It is the general successor to the fixed, registered shift-by-one stage, adding variable amounts, right/arithmetic shifts, optional rotates and flow control.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_step.sv | 44 ++++
 rtl/shift_seq_unit.sv | 105 ++++++++++
 tb/tb_shift_seq_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the bit_shift library: shift modes, FSM states and
// the reserved-mode boundary.
package shift_pkg;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // Encodings at or above this value are reserved.
  localparam logic [2:0] MODE_FIRST_RSVD = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_reserved(input logic [2:0] mode);
    return mode >= MODE_FIRST_RSVD;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-position shift/rotate step, purely combinational.
// Rotate modes exist only when SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] next_data,
  output logic             carry
);

  always_comb begin
    next_data = data;
    carry     = 1'b0;
    case (mode)
      MODE_LSL: begin
        next_data = {data[WIDTH-2:0], 1'b0};
        carry     = data[WIDTH-1];
      end
      MODE_LSR: begin
        next_data = {1'b0, data[WIDTH-1:1]};
        carry     = data[0];
      end
      MODE_ASR: begin
        next_data = {data[WIDTH-1], data[WIDTH-1:1]};
        carry     = data[0];
      end
`ifdef SHIFT_ROTATE_EN
      MODE_ROL: begin
        next_data = {data[WIDTH-2:0], data[WIDTH-1]};
        carry     = data[WIDTH-1];
      end
      MODE_ROR: begin
        next_data = {data[0], data[WIDTH-1:1]};
        carry     = data[0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Handshaked multi-cycle shift engine, one position per clock.
// SHIFT_ROTATE_EN enables ROL/ROR; otherwise they run as LSL/LSR.
//
// state    | meaning
// ST_IDLE  | in_ready high, waiting for a request
// ST_SHIFT | stepping working register, counter down to terminal count 1
// ST_DONE  | result presented on out_valid until out_ready
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         state_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [2:0]         mode_q;
  logic               carry_q;
  logic               clr_q;

  logic [WIDTH-1:0]   step_data;
  logic               step_carry;
  logic [2:0]         acc_mode;
  logic               acc_rsvd;
  logic               acc_clr;
  logic               accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data      (work_q),
    .mode      (mode_q),
    .next_data (step_data),
    .carry     (step_carry)
  );

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = work_q;
  assign accept    = in_valid && in_ready;
  // Shifting LSL/LSR by exactly WIDTH would leave the last real bit in carry;
  // logical shifts of WIDTH or more report carry 0.
  assign out_carry = carry_q && !clr_q;

  always_comb begin
    acc_mode = in_mode;
    acc_rsvd = is_reserved(in_mode);
`ifndef SHIFT_ROTATE_EN
    if (in_mode == MODE_ROL) acc_mode = MODE_LSL;
    if (in_mode == MODE_ROR) acc_mode = MODE_LSR;
`endif
    acc_clr = (32'(in_amt) >= 32'(WIDTH)) &&
              ((acc_mode == MODE_LSL) || (acc_mode == MODE_LSR));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_LSL;
      carry_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            work_q  <= in_data;
            cnt_q   <= in_amt;
            mode_q  <= acc_mode;
            carry_q <= 1'b0;
            clr_q   <= acc_clr;
            state_q <= (in_amt == '0 || acc_rsvd) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_q  <= step_data;
          carry_q <= step_carry;
          cnt_q   <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit (WIDTH=8, SHAMT_W=4); expectations
// follow SHIFT_ROTATE_EN when set.
module tb_shift_seq_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_amt;
  logic [2:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic       busy;

  int tests = 0;
  int fails = 0;

  shift_seq_unit #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; the request is accepted on the next edge.
  task automatic req(input string tag, input logic [7:0] d, input logic [3:0] a,
                     input logic [2:0] m, input logic [7:0] ed, input logic ec,
                     input int lat, input int hold);
    int cyc;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check({tag, "_ready"}, in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_data  = d ^ 8'h5A;
    in_amt   = ~a;
    in_mode  = 3'b001;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_noready"}, in_ready, 0);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_carry"}, out_carry, ec);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_data"}, out_data, ed);
      check({tag, "_hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, "_post_ready"}, in_ready, 1);
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_carry", out_carry, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rel_ready", in_ready, 1);
    @(posedge clock); #1;

    // Reset two shifts into an LSL by 5 aborts the request.
    in_data  = 8'h0F;
    in_amt   = 4'd5;
    in_mode  = 3'b000;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    check("mid_data", out_data, 8'h3C);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 8'h00);
    check("abort_carry", out_carry, 0);
    check("abort_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_rel_ready", in_ready, 1);
    repeat (3) begin
      @(posedge clock); #1;
      check("abort_no_valid", out_valid, 0);
    end
    req("fresh_lsl", 8'h0F, 4'd5, 3'b000, 8'hE0, 1'b1, 5, 0);

    req("lsl1", 8'b1011_0001, 4'd1, 3'b000, 8'b0110_0010, 1'b1, 1, 4);
    req("asr3", 8'h90, 4'd3, 3'b010, 8'hF2, 1'b0, 3, 0);
    // Last bit out of an ASR by 7 is operand bit 6, which is 0 for 0x80.
    req("asr7", 8'h80, 4'd7, 3'b010, 8'hFF, 1'b0, 7, 0);
    req("asr8", 8'h80, 4'd8, 3'b010, 8'hFF, 1'b1, 8, 0);
    req("lsr7", 8'hFF, 4'd7, 3'b001, 8'h01, 1'b1, 7, 0);
    req("lsr12", 8'hFF, 4'd12, 3'b001, 8'h00, 1'b0, 12, 0);
    req("lsl8", 8'h81, 4'd8, 3'b000, 8'h00, 1'b0, 8, 0);
    req("lsr8", 8'h81, 4'd8, 3'b001, 8'h00, 1'b0, 8, 0);
`ifdef SHIFT_ROTATE_EN
    req("rol1", 8'h81, 4'd1, 3'b011, 8'h03, 1'b1, 1, 0);
    req("ror8", 8'h81, 4'd8, 3'b100, 8'h81, 1'b1, 8, 0);
    req("ror3", 8'h06, 4'd3, 3'b100, 8'hC0, 1'b1, 3, 0);
`else
    req("rol1", 8'h81, 4'd1, 3'b011, 8'h02, 1'b1, 1, 0);
    req("ror8", 8'h81, 4'd8, 3'b100, 8'h00, 1'b0, 8, 0);
    req("ror3", 8'h06, 4'd3, 3'b100, 8'h00, 1'b1, 3, 0);
`endif
    req("rol0", 8'h81, 4'd0, 3'b011, 8'h81, 1'b0, 0, 0);
    req("rsvd", 8'hA5, 4'd5, 3'b110, 8'hA5, 1'b0, 0, 2);
    req("asr0", 8'h90, 4'd0, 3'b010, 8'h90, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
